// File: rtl/capture_ila_if.sv
// Read-port bundle for capture_ila: the host side (master) issues reads and
// the capture core (slave) returns captured samples.
interface capture_ila_if #(
  parameter int PROBE_W = 32,
  parameter int ADDR_W  = 8
);
  // Handshake: the host pulses rd_en with rd_addr in the same cycle. The core
  // answers exactly one cycle later with rd_data qualified by rd_valid. There
  // is no backpressure, so every rd_en produces one rd_valid and reads may be
  // issued back to back.
  logic               rd_en;
  logic [ADDR_W-1:0]  rd_addr;
  logic [PROBE_W-1:0] rd_data;
  logic               rd_valid;

  modport master (
    output rd_en,
    output rd_addr,
    input  rd_data,
    input  rd_valid
  );

  modport slave (
    input  rd_en,
    input  rd_addr,
    output rd_data,
    output rd_valid
  );
endinterface

// File: rtl/capture_ila.sv
// capture_ila: on-chip logic-analyser capture core.
// Samples a PROBE_W-bit probe bus into a circular buffer of DEPTH words,
// fires on a masked value or rising-edge-of-match trigger, retains a
// programmable number of pre-trigger samples and exposes the captured window
// through a one-cycle-latency read port addressed by logical index.
// Optional build macro CAPTURE_ILA_STORAGE_QUAL_EN adds a 'qual' input that
// gates storage (and trigger evaluation) to qualified cycles only.
module capture_ila #(
  parameter int PROBE_W = 32,
  parameter int DEPTH   = 256,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [PROBE_W-1:0] probe,
`ifdef CAPTURE_ILA_STORAGE_QUAL_EN
  input  logic               qual,
`endif
  input  logic               arm,
  input  logic [PROBE_W-1:0] trig_mask,
  input  logic [PROBE_W-1:0] trig_value,
  input  logic               trig_edge,
  input  logic [ADDR_W-1:0]  pretrig,
  output logic               busy,
  output logic               triggered,
  output logic               done,
  output logic [ADDR_W-1:0]  trig_addr,
  output logic [2:0]         dbg_state,
  capture_ila_if.slave       rd
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PRE  = 3'd1,
    S_WAIT = 3'd2,
    S_POST = 3'd3,
    S_DONE = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  // Sample storage; contents are only meaningful once the window is complete.
  logic [PROBE_W-1:0] r_mem [DEPTH];

  state_t             r_state;
  logic [ADDR_W-1:0]  r_wr_ptr;
  logic [ADDR_W-1:0]  r_pre_cnt;
  logic [ADDR_W-1:0]  r_post_cnt;
  logic [ADDR_W-1:0]  r_pre_eff;
  logic [ADDR_W-1:0]  r_trig_addr;
  logic               r_triggered;
  logic               r_match_d;
  logic [PROBE_W-1:0] r_rd_data;
  logic               r_rd_valid;

  state_t             w_state_nxt;
  logic [ADDR_W-1:0]  w_wr_ptr_nxt;
  logic [ADDR_W-1:0]  w_pre_cnt_nxt;
  logic [ADDR_W-1:0]  w_post_cnt_nxt;
  logic [ADDR_W-1:0]  w_pre_eff_nxt;
  logic [ADDR_W-1:0]  w_trig_addr_nxt;
  logic               w_triggered_nxt;
  logic               w_match_d_nxt;
  logic               w_we;

  logic               w_qual;
  logic               w_match;
  logic               w_hit;
  logic [ADDR_W-1:0]  w_post_init;
  logic [ADDR_W-1:0]  w_rd_phys;

`ifdef CAPTURE_ILA_STORAGE_QUAL_EN
  assign w_qual = qual;
`else
  assign w_qual = 1'b1;
`endif

  // A zero mask makes every bit a don't-care, so match is then constantly 1.
  assign w_match = (((probe ^ trig_value) & trig_mask) == '0);

  // Edge mode fires only when match goes 0->1 between qualified samples.
  assign w_hit = w_qual & (trig_edge ? (w_match & ~r_match_d) : w_match);

  // Samples still to store after the trigger sample so the window is DEPTH long.
  assign w_post_init = LAST - r_pre_eff;

  // Logical index 0 is the oldest sample: trigger address minus pre-trigger depth.
  assign w_rd_phys = r_trig_addr - r_pre_eff + rd.rd_addr;

  // Next-state and datapath control for the capture sequencer.
  always_comb begin
    w_state_nxt     = r_state;
    w_wr_ptr_nxt    = r_wr_ptr;
    w_pre_cnt_nxt   = r_pre_cnt;
    w_post_cnt_nxt  = r_post_cnt;
    w_pre_eff_nxt   = r_pre_eff;
    w_trig_addr_nxt = r_trig_addr;
    w_triggered_nxt = r_triggered;
    w_match_d_nxt   = r_match_d;
    w_we            = 1'b0;

    if (arm) begin
      // Restart from any state. The ADDR_W-bit pretrig field cannot exceed
      // DEPTH-1, so the clamp to DEPTH-1 is implicit in its width. match_d is
      // preset so a match already present at arm cannot look like an edge.
      w_pre_eff_nxt   = pretrig;
      w_wr_ptr_nxt    = '0;
      w_pre_cnt_nxt   = '0;
      w_triggered_nxt = 1'b0;
      w_match_d_nxt   = 1'b1;
      w_state_nxt     = (pretrig == '0) ? S_WAIT : S_PRE;
    end else begin
      unique case (r_state)
        S_PRE: begin
          // Fill the pre-trigger history; hits are ignored here.
          if (w_qual) begin
            w_we          = 1'b1;
            w_wr_ptr_nxt  = r_wr_ptr + ONE;
            w_pre_cnt_nxt = r_pre_cnt + ONE;
            w_match_d_nxt = w_match;
            if ((r_pre_cnt + ONE) == r_pre_eff) begin
              w_state_nxt = S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // Keep overwriting the oldest sample until the trigger arrives;
          // the trigger sample itself is stored this cycle.
          if (w_qual) begin
            w_we          = 1'b1;
            w_wr_ptr_nxt  = r_wr_ptr + ONE;
            w_match_d_nxt = w_match;
            if (w_hit) begin
              w_trig_addr_nxt = r_wr_ptr;
              w_triggered_nxt = 1'b1;
              w_post_cnt_nxt  = w_post_init;
              w_state_nxt     = (w_post_init == '0) ? S_DONE : S_POST;
            end
          end
        end
        S_POST: begin
          // Store the remaining post-trigger samples, then freeze.
          if (w_qual) begin
            w_we           = 1'b1;
            w_wr_ptr_nxt   = r_wr_ptr + ONE;
            w_post_cnt_nxt = r_post_cnt - ONE;
            w_match_d_nxt  = w_match;
            if (r_post_cnt == ONE) begin
              w_state_nxt = S_DONE;
            end
          end
        end
        default: begin
          // IDLE and DONE hold everything and write nothing.
        end
      endcase
    end
  end

  // Sequencer and capture-control registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_wr_ptr    <= '0;
      r_pre_cnt   <= '0;
      r_post_cnt  <= '0;
      r_pre_eff   <= '0;
      r_trig_addr <= '0;
      r_triggered <= 1'b0;
      r_match_d   <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_pre_cnt   <= w_pre_cnt_nxt;
      r_post_cnt  <= w_post_cnt_nxt;
      r_pre_eff   <= w_pre_eff_nxt;
      r_trig_addr <= w_trig_addr_nxt;
      r_triggered <= w_triggered_nxt;
      r_match_d   <= w_match_d_nxt;
    end
  end

  // Sample buffer write port; RAM contents are intentionally not reset.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[r_wr_ptr] <= probe;
    end
  end

  // Registered read port: data and its qualifier appear one cycle after rd_en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      r_rd_valid <= rd.rd_en;
      if (rd.rd_en) begin
        r_rd_data <= r_mem[w_rd_phys];
      end
    end
  end

  assign busy        = (r_state == S_PRE) || (r_state == S_WAIT) || (r_state == S_POST);
  assign done        = (r_state == S_DONE);
  assign triggered   = r_triggered;
  assign trig_addr   = r_trig_addr;
  assign dbg_state   = r_state;
  assign rd.rd_data  = r_rd_data;
  assign rd.rd_valid = r_rd_valid;

endmodule

// File: tb/tb_capture_ila.sv
// Bench for capture_ila (DEPTH=16, PROBE_W=8). The probe is a free-running
// 8-bit counter that restarts from a chosen value on the cycle after arm.
// Read expectations are queued as reads are issued; a monitor pops and
// compares whenever rd_valid is presented.
module tb_capture_ila;

  localparam int PW = 8;
  localparam int DP = 16;
  localparam int AW = 4;

  logic          clk;
  logic          rst_n;
  logic [PW-1:0] probe;
  logic          arm;
  logic [PW-1:0] trig_mask;
  logic [PW-1:0] trig_value;
  logic          trig_edge;
  logic [AW-1:0] pretrig;
  logic          busy;
  logic          triggered;
  logic          done;
  logic [AW-1:0] trig_addr;
  logic [2:0]    dbg_state;
`ifdef CAPTURE_ILA_STORAGE_QUAL_EN
  logic          qual;
  logic          qual_mode;
`endif

  logic [PW-1:0] cnt_start;
  logic [PW-1:0] exp_q[$];
  string         tag_q[$];
  int            n_cmp;
  int            n_err;
  logic [PW-1:0] p_done;

  capture_ila_if #(.PROBE_W(PW), .ADDR_W(AW)) rd_if ();

  capture_ila #(.PROBE_W(PW), .DEPTH(DP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .probe      (probe),
`ifdef CAPTURE_ILA_STORAGE_QUAL_EN
    .qual       (qual),
`endif
    .arm        (arm),
    .trig_mask  (trig_mask),
    .trig_value (trig_value),
    .trig_edge  (trig_edge),
    .pretrig    (pretrig),
    .busy       (busy),
    .triggered  (triggered),
    .done       (done),
    .trig_addr  (trig_addr),
    .dbg_state  (dbg_state),
    .rd         (rd_if.slave)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  // ---------------- driver tasks ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
    probe = arm ? cnt_start : probe + 8'd1;
`ifdef CAPTURE_ILA_STORAGE_QUAL_EN
    qual = qual_mode ? ~probe[0] : 1'b1;
`endif
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic arm_capture(input logic [PW-1:0] m, input logic [PW-1:0] v,
                             input logic e, input logic [AW-1:0] p,
                             input logic [PW-1:0] start);
    trig_mask  = m;
    trig_value = v;
    trig_edge  = e;
    pretrig    = p;
    cnt_start  = start;
    arm        = 1'b1;
    cycle();
    arm        = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget, output logic [PW-1:0] p_at);
    bit got;
    got = 1'b0;
    for (int k = 0; k < budget; k++) begin
      cycle();
      if (done === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: done=0 after %0d cycles, required 1", name, budget);
    end
    p_at = probe;
  endtask

  task automatic wait_trig(input string name, input int budget);
    bit got;
    got = 1'b0;
    for (int k = 0; k < budget; k++) begin
      cycle();
      if (triggered === 1'b1) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s_timeout: triggered=0 after %0d cycles, required 1", name, budget);
    end
  endtask

  // Read the whole window; expected sample i is base + i*step (8-bit wrap).
  task automatic read_window(input string name, input logic [PW-1:0] base, input int step);
    logic [PW-1:0] e;
    for (int i = 0; i < DP; i++) begin
      rd_if.rd_en   = 1'b1;
      rd_if.rd_addr = AW'(i);
      e = base + PW'(i * step);
      exp_q.push_back(e);
      tag_q.push_back($sformatf("%s[%0d]", name, i));
      cycle();
    end
    rd_if.rd_en = 1'b0;
    cycle();
    cycle();
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(negedge clk) begin
    logic [PW-1:0] e;
    string t;
    if (rd_if.rd_valid === 1'b1) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rd_unexpected: got rd_valid with data 0x%0h, required no response", rd_if.rd_data);
      end else begin
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        if (rd_if.rd_data !== e) begin
          n_err++;
          $display("FAIL %s: got 0x%0h, required 0x%0h", t, rd_if.rd_data, e);
        end
      end
    end
  end

  // ---------------- directed sequence ----------------
  initial begin
    n_cmp         = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    probe         = '0;
    arm           = 1'b0;
    trig_mask     = '0;
    trig_value    = '0;
    trig_edge     = 1'b0;
    pretrig       = '0;
    cnt_start     = '0;
    rd_if.rd_en   = 1'b0;
    rd_if.rd_addr = '0;
`ifdef CAPTURE_ILA_STORAGE_QUAL_EN
    qual_mode     = 1'b0;
    qual          = 1'b1;
`endif

    // Reset values.
    #2;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_triggered", 32'(triggered), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_trig_addr", 32'(trig_addr), 32'd0);
    check("rst_rd_data", 32'(rd_if.rd_data), 32'd0);
    check("rst_rd_valid", 32'(rd_if.rd_valid), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
    cycle();
    cycle();
    rst_n = 1'b1;
    cycle();

    // Level trigger at 0x20, 4 pre-trigger samples.
    arm_capture(8'hFF, 8'h20, 1'b0, 4'd4, 8'h00);
    check("t1_busy_after_arm", 32'(busy), 32'd1);
    check("t1_state_pre", 32'(dbg_state), 32'd1);
    check("t1_trig_clear", 32'(triggered), 32'd0);
    wait_done("t1", 200, p_done);
    check("t1_done_timing", 32'(p_done), 32'h2C);
    check("t1_triggered", 32'(triggered), 32'd1);
    check("t1_busy_done", 32'(busy), 32'd0);
    check("t1_trig_addr", 32'(trig_addr), 32'd0);
    read_window("t1_win", 8'h1C, 1);

    // pretrig 15 with trigger 0x20: window ends at the trigger sample.
    arm_capture(8'hFF, 8'h20, 1'b0, 4'd15, 8'h00);
    wait_done("t3", 200, p_done);
    check("t3_trig_addr", 32'(trig_addr), 32'd0);
    read_window("t3_win", 8'h11, 1);

    // Trigger value 0x03 shows up during PRE and is ignored; next 0x03 wins.
    arm_capture(8'hFF, 8'h03, 1'b0, 4'd15, 8'h00);
    wait_done("t4", 400, p_done);
    check("t4_done_timing", 32'(p_done), 32'h04);
    check("t4_trig_addr", 32'(trig_addr), 32'd3);
    read_window("t4_win", 8'hF4, 1);

    // Edge trigger on bit 0: first odd sample after arm.
    arm_capture(8'h01, 8'h01, 1'b1, 4'd0, 8'h00);
    wait_done("t5", 100, p_done);
    check("t5_trig_addr", 32'(trig_addr), 32'd1);
    read_window("t5_win", 8'h01, 1);

    // Edge trigger with a match already true at arm: 0x11 must not fire,
    // the next 0x10 (after the counter wraps) must.
    arm_capture(8'hFE, 8'h10, 1'b1, 4'd0, 8'h11);
    wait_done("t6", 400, p_done);
    check("t6_trig_addr", 32'(trig_addr), 32'd15);
    read_window("t6_win", 8'h10, 1);

    // Edge mode with empty mask never fires.
    arm_capture(8'h00, 8'h00, 1'b1, 4'd3, 8'h00);
    for (int k = 0; k < 1000; k++) cycle();
    check("t7_busy", 32'(busy), 32'd1);
    check("t7_triggered", 32'(triggered), 32'd0);
    check("t7_done", 32'(done), 32'd0);
    check("t7_state_wait", 32'(dbg_state), 32'd2);

    // Re-arm in the middle of POST.
    arm_capture(8'hFF, 8'h08, 1'b0, 4'd2, 8'h00);
    wait_trig("t8", 100);
    cycle();
    cycle();
    cycle();
    check("t8_state_post", 32'(dbg_state), 32'd3);
    arm_capture(8'hFF, 8'h08, 1'b0, 4'd2, 8'h00);
    check("t8_rearm_triggered", 32'(triggered), 32'd0);
    check("t8_rearm_done", 32'(done), 32'd0);
    check("t8_rearm_busy", 32'(busy), 32'd1);
    wait_done("t8", 200, p_done);
    check("t8_done_timing", 32'(p_done), 32'h16);
    check("t8_trig_addr", 32'(trig_addr), 32'd8);
    read_window("t8_win", 8'h06, 1);

    // Asynchronous reset in the middle of WAIT.
    arm_capture(8'hFF, 8'hF0, 1'b0, 4'd2, 8'h00);
    for (int k = 0; k < 10; k++) cycle();
    check("t9_state_wait", 32'(dbg_state), 32'd2);
    #2;
    rst_n = 1'b0;
    #1;
    check("t9_busy", 32'(busy), 32'd0);
    check("t9_triggered", 32'(triggered), 32'd0);
    check("t9_done", 32'(done), 32'd0);
    check("t9_trig_addr", 32'(trig_addr), 32'd0);
    check("t9_state_idle", 32'(dbg_state), 32'd0);
    #3;
    rst_n = 1'b1;
    cycle();

    // pretrig 0 goes straight to WAIT; capture recovers after reset.
    arm_capture(8'hFF, 8'h05, 1'b0, 4'd0, 8'h00);
    check("t2_state_wait", 32'(dbg_state), 32'd2);
    wait_done("t2", 100, p_done);
    check("t2_trig_addr", 32'(trig_addr), 32'd5);
    read_window("t2_win", 8'h05, 1);

`ifdef CAPTURE_ILA_STORAGE_QUAL_EN
    // Store only even samples.
    qual_mode = 1'b1;
    arm_capture(8'hFF, 8'h20, 1'b0, 4'd4, 8'h00);
    wait_done("tq", 200, p_done);
    check("tq_done_timing", 32'(p_done), 32'h37);
    read_window("tq_win", 8'h18, 2);
    qual_mode = 1'b0;
`endif

    cycle();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
